// File: rtl/gcd_job_driver.sv
// gcd_job_driver
//   Initiator-side front end for the _gcd core. Takes one operand pair at a
//   time from a valid/ready input stream, runs it through the core (or
//   resolves it locally when an operand is zero), and offers the result on a
//   valid/ready output stream. A job that the core never finishes is
//   abandoned after TIMEOUT wait cycles and reported as a timeout.
//
// Ports
//   _clock, _reset          clock (rising edge), async active-low reset
//   _in_valid/_in_ready     operand stream handshake, operands _in_a/_in_b
//   _core_start/_num0/_num1 request to the core, held for the whole job
//   _core_greatest/_success core result
//   _out_valid/_out_ready   result stream handshake, _out_gcd/_out_timeout
//   _busy                   a job is in flight
//   _job_count              completed output handshakes (wraps)
module gcd_job_driver #(
    parameter int W       = 8,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic          _clock,
    input  logic          _reset,
    input  logic          _in_valid,
    input  logic [W-1:0]  _in_a,
    input  logic [W-1:0]  _in_b,
    output logic          _in_ready,
    output logic          _core_start,
    output logic [W-1:0]  _core_num0,
    output logic [W-1:0]  _core_num1,
    input  logic [W-1:0]  _core_greatest,
    input  logic          _core_success,
    output logic          _out_valid,
    output logic [W-1:0]  _out_gcd,
    output logic          _out_timeout,
    input  logic          _out_ready,
    output logic          _busy,
    output logic [CW-1:0] _job_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t        state, state_d;
    logic [W-1:0]  num0_d, num1_d, gcd_d;
    logic          to_d;
    logic [TW-1:0] cnt, cnt_d;
    logic [CW-1:0] jc_d;
    logic          in_ready_d, start_d, out_valid_d, busy_d;

    always_comb begin
        state_d = state;
        num0_d  = _core_num0;
        num1_d  = _core_num1;
        gcd_d   = _out_gcd;
        to_d    = _out_timeout;
        cnt_d   = cnt;
        jc_d    = _job_count;
        case (state)
            IDLE: begin
                if (_in_valid) begin
                    if (_in_a == '0 || _in_b == '0) begin
                        // gcd(x,0) = x and gcd(0,0) = 0 both fall out of a|b
                        gcd_d   = _in_a | _in_b;
                        to_d    = 1'b0;
                        state_d = RESULT;
                    end else begin
                        num0_d  = _in_a;
                        num1_d  = _in_b;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // success may still be high from the previous job here, so
                // it is deliberately not looked at
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // success is checked first so it wins over a same-cycle timeout
                if (_core_success) begin
                    gcd_d   = _core_greatest;
                    to_d    = 1'b0;
                    state_d = RESULT;
                end else if (cnt == TLAST) begin
                    gcd_d   = '0;
                    to_d    = 1'b1;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESULT: begin
                if (_out_ready) begin
                    jc_d    = _job_count + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // status outputs are decoded from the next state so they come
        // straight out of flops
        in_ready_d  = (state_d == IDLE);
        start_d     = (state_d == ISSUE) || (state_d == WAIT);
        out_valid_d = (state_d == RESULT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state        <= IDLE;
            _core_num0   <= '0;
            _core_num1   <= '0;
            _out_gcd     <= '0;
            _out_timeout <= 1'b0;
            cnt          <= '0;
            _job_count   <= '0;
            _in_ready    <= 1'b1;
            _core_start  <= 1'b0;
            _out_valid   <= 1'b0;
            _busy        <= 1'b0;
        end else begin
            state        <= state_d;
            _core_num0   <= num0_d;
            _core_num1   <= num1_d;
            _out_gcd     <= gcd_d;
            _out_timeout <= to_d;
            cnt          <= cnt_d;
            _job_count   <= jc_d;
            _in_ready    <= in_ready_d;
            _core_start  <= start_d;
            _out_valid   <= out_valid_d;
            _busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_gcd_job_driver.sv
module tb_gcd_job_driver;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic       in_ready;
    logic       core_start;
    logic [7:0] core_num0, core_num1;
    logic [7:0] core_greatest = '0;
    logic       core_success = 1'b0;
    logic       out_valid;
    logic [7:0] out_gcd;
    logic       out_timeout;
    logic       out_ready = 1'b0;
    logic       busy;
    logic [1:0] job_count;

    int checks = 0;
    int failures = 0;
    int lat = -1;  // core stub latency for the current job, -1 = never answers

    gcd_job_driver #(.W(8), .TIMEOUT(TO), .CW(2)) dut (
        ._clock(clk), ._reset(rst),
        ._in_valid(in_valid), ._in_a(in_a), ._in_b(in_b), ._in_ready(in_ready),
        ._core_start(core_start), ._core_num0(core_num0), ._core_num1(core_num1),
        ._core_greatest(core_greatest), ._core_success(core_success),
        ._out_valid(out_valid), ._out_gcd(out_gcd), ._out_timeout(out_timeout),
        ._out_ready(out_ready), ._busy(busy), ._job_count(job_count)
    );

    always #5 clk = ~clk;

    function automatic int gcd_fn(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Core stub: success is sticky until the next start rising edge, so a
    // stale success is visible while the driver sits in its issue cycle.
    logic stub_prev = 1'b0;
    int   stub_cnt = 0;
    always @(posedge clk) begin
        stub_prev <= core_start;
        if (core_start && !stub_prev) begin
            core_success <= 1'b0;
            stub_cnt     <= 1;
        end else if (core_start) begin
            stub_cnt <= stub_cnt + 1;
            if (lat >= 1 && stub_cnt >= lat) begin
                core_success  <= 1'b1;
                core_greatest <= 8'(gcd_fn(int'(core_num0), int'(core_num1)));
            end
        end
    end

    // Reference model: counts cycles since the accepting edge and knows
    // when the result must appear and what it must be.
    bit   m_inflight = 0, m_core = 0, m_to = 0;
    int   m_k = 0, m_rise = 0, m_gcd = 0, m_jc = 0;
    logic [7:0] m_n0 = '0, m_n1 = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_inflight = 0; m_jc = 0; m_n0 = '0; m_n1 = '0;
        end else if (!m_inflight) begin
            if (in_valid) begin
                m_inflight = 1;
                m_k = 1;
                m_core = (in_a != 0) && (in_b != 0);
                if (!m_core) begin
                    m_rise = 1; m_gcd = int'(in_a | in_b); m_to = 0;
                end else begin
                    m_n0 = in_a; m_n1 = in_b;
                    if (lat >= 1 && lat + 1 <= TO) begin
                        m_rise = lat + 3; m_gcd = gcd_fn(int'(in_a), int'(in_b)); m_to = 0;
                    end else begin
                        m_rise = TO + 2; m_gcd = 0; m_to = 1;
                    end
                end
            end
        end else if (m_k >= m_rise && out_ready) begin
            m_inflight = 0;
            m_jc = (m_jc + 1) % 4;
        end else begin
            m_k++;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && rst) begin
            automatic bit ev = m_inflight && (m_k >= m_rise);
            automatic bit es = m_inflight && m_core && (m_k < m_rise);
            chk("in_ready",   32'(in_ready),   32'(!m_inflight));
            chk("busy",       32'(busy),       32'(m_inflight));
            chk("out_valid",  32'(out_valid),  32'(ev));
            chk("core_start", 32'(core_start), 32'(es));
            chk("core_num0",  32'(core_num0),  32'(m_n0));
            chk("core_num1",  32'(core_num1),  32'(m_n1));
            chk("job_count",  32'(job_count),  32'(m_jc));
            if (ev) begin
                chk("out_gcd",     32'(out_gcd),     32'(m_gcd));
                chk("out_timeout", 32'(out_timeout), 32'(m_to));
            end
        end
    end

    // eg/et/ejc < 0 skip the hand-computed literal checks
    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int l,
                           input int hold, input int eg, input int et, input int ejc,
                           input bit spurious);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin chk("in_ready_wait", 32'(in_ready), 32'd1); return; end
        lat = l; in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) begin chk("out_valid_wait", 32'(out_valid), 32'd1); return; end
        if (eg >= 0) chk("lit_gcd", 32'(out_gcd), 32'(eg));
        if (et >= 0) chk("lit_timeout", 32'(out_timeout), 32'(et));
        for (int i = 0; i < hold; i++) begin
            if (spurious && i == 1) begin in_valid = 1'b1; in_a = 8'd9; in_b = 8'd3; end
            @(negedge clk);
            in_valid = 1'b0;
        end
        if (eg >= 0 && hold > 0) chk("lit_gcd_held", 32'(out_gcd), 32'(eg));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (ejc >= 0) chk("lit_job_count", 32'(job_count), 32'(ejc));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_start",     32'(core_start),  32'd0);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_gcd",       32'(out_gcd),     32'd0);
        chk("rst_timeout",   32'(out_timeout), 32'd0);
        chk("rst_num0",      32'(core_num0),   32'd0);
        chk("rst_jc",        32'(job_count),   32'd0);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        cmp_en = 1;

        run_job(8'd36, 8'd24, 3, 0, 12, 0, 1, 0);
        run_job(8'd0,  8'd15, 2, 0, 15, 0, 2, 0);
        run_job(8'd0,  8'd0,  2, 0, 0,  0, 3, 0);
        run_job(8'd50, 8'd20, -1, 0, 0, 1, 0, 0);     // core never answers
        run_job(8'd48, 8'd18, 2, 0, 6,  0, 1, 0);
        run_job(8'd21, 8'd14, 1, 5, 7,  0, 2, 1);     // backpressure + ignored input
        run_job(8'd12, 8'd8,  7, 0, 4,  0, 3, 0);     // success on the timeout cycle

        // reset in the middle of a wait
        lat = -1; in_a = 8'd100; in_b = 8'd75; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_start", 32'(core_start), 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("arst_start",     32'(core_start), 32'd0);
        chk("arst_out_valid", 32'(out_valid),  32'd0);
        chk("arst_busy",      32'(busy),       32'd0);
        chk("arst_in_ready",  32'(in_ready),   32'd1);
        chk("arst_jc",        32'(job_count),  32'd0);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);

        run_job(8'd100, 8'd75, 2, 0, 25, 0, 1, 0);
        run_job(8'd9,   8'd6,  1, 1, 3,  0, 2, 0);
        run_job(8'd7,   8'd0,  1, 0, 7,  0, 3, 0);
        run_job(8'd81,  8'd27, 4, 0, 27, 0, 0, 0);

        for (int j = 0; j < 30; j++) begin
            automatic logic [7:0] ra = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            automatic logic [7:0] rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            automatic int r = int'($urandom_range(0, 9));
            run_job(ra, rb, (r == 0) ? -1 : r, int'($urandom_range(0, 3)), -1, -1, -1, 0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
